// File: rtl/spi_pwm_cfg_pkg.sv
// Shared definitions for the SPI PWM configuration controller.
// Register addresses, FSM state encoding and frame field constants.
package spi_pwm_cfg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_pwm_config_ctrl_sync_edge_det.sv
// Multi-flop synchroniser with single-cycle rise/fall pulses on the
// synchronised level. RESET_VAL sets the idle level the chain resets to.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchroniser chain plus one delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_pwm_config_ctrl.sv
// SPI mode-0 write peripheral configuring the PWM enable/duty registers.
// Optional feature macro: SPI_READBACK_EN (read frames drive cipo).
import spi_pwm_cfg_pkg::*;

module spi_pwm_config_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_ADDR    = 4,
    parameter int unsigned FRAME_BITS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_err
);

    localparam int unsigned CW       = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);
    localparam logic [6:0]    MAX_A    = 7'(MAX_ADDR);

    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_s, ncs_rise, ncs_fall;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i (clk), .rst_ni(rst_n), .d_i(sclk),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk_i (clk), .rst_ni(rst_n), .d_i(copi),
        .sync_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk_i (clk), .rst_ni(rst_n), .d_i(ncs),
        .sync_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );

    // Edge pulses not needed by every build configuration.
    logic unused_edges;
    assign unused_edges = ^{copi_rise, copi_fall, sclk_fall, sclk_s};

    state_t                state_q;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            reg0_q, reg1_q, reg2_q, reg3_q, reg4_q;
    logic                  frame_err_q;

    logic       f_rw;
    logic [6:0] f_addr;
    logic [7:0] f_data;

    assign f_rw   = shift_q[FRAME_BITS-1];
    assign f_addr = shift_q[FRAME_BITS-2 -: 7];
    assign f_data = shift_q[7:0];

    // Next shift/count values for a sampled SPI bit; count saturates.
    always_comb begin
        shift_d = {shift_q[FRAME_BITS-2:0], copi_s};
        cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
    end

    // Deframing FSM with registered config outputs and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            reg0_q      <= '0;
            reg1_q      <= '0;
            reg2_q      <= '0;
            reg3_q      <= '0;
            reg4_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ncs_fall) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ncs_rise) begin
                        if (cnt_q == CNT_FULL) begin
                            state_q <= ST_COMMIT;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end else if (sclk_rise) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_d;
                    end
                end
                ST_COMMIT: begin
                    if (f_rw == RW_WRITE && f_addr <= MAX_A) begin
                        case (f_addr)
                            ADDR_EN_OUT_LO: reg0_q <= f_data;
                            ADDR_EN_OUT_HI: reg1_q <= f_data;
                            ADDR_EN_PWM_LO: reg2_q <= f_data;
                            ADDR_EN_PWM_HI: reg3_q <= f_data;
                            ADDR_DUTY:      reg4_q <= f_data;
                            default:        ;
                        endcase
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = reg0_q;
    assign en_reg_out_15_8 = reg1_q;
    assign en_reg_pwm_7_0  = reg2_q;
    assign en_reg_pwm_15_8 = reg3_q;
    assign pwm_duty_cycle  = reg4_q;
    assign frame_err       = frame_err_q;

`ifdef SPI_READBACK_EN
    logic [7:0] tx_q;
    logic       cipo_q;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    // Address as it stands once the 8th bit is being shifted in.
    assign rd_addr = {shift_q[5:0], copi_s};

    // Read mux; out-of-range addresses read as zero.
    always_comb begin
        rd_data = '0;
        case (rd_addr)
            ADDR_EN_OUT_LO: rd_data = reg0_q;
            ADDR_EN_OUT_HI: rd_data = reg1_q;
            ADDR_EN_PWM_LO: rd_data = reg2_q;
            ADDR_EN_PWM_HI: rd_data = reg3_q;
            ADDR_DUTY:      rd_data = reg4_q;
            default:        rd_data = '0;
        endcase
    end

    // Load on the 8th rising edge of a read frame, present MSB-first on falls.
    // The R/W bit sits at shift_q[6] just before the 8th shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_q   <= '0;
            cipo_q <= 1'b0;
        end else if (state_q != ST_SHIFT || ncs_s) begin
            tx_q   <= '0;
            cipo_q <= 1'b0;
        end else if (sclk_rise && cnt_q == CW'(7) && shift_q[6] != RW_WRITE) begin
            tx_q <= rd_data;
        end else if (sclk_fall) begin
            cipo_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
        end
    end

    assign cipo = cipo_q;
`else
    assign cipo = 1'b0;
`endif

endmodule
